// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encodings and sizes for the shift-add multiplier
package mult_pkg;

    localparam int DATA_W     = 32;
    localparam int ITER_COUNT = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC   = 3'd1,
        NEG_LO = 3'd2,
        NEG_HI = 3'd3,
        DONE   = 3'd4
    } mult_state_t;

endpackage

// File: rtl/_32bit_adder.sv
// rtl/_32bit_adder.sv - 32-bit ripple adder with carry in/out
module _32bit_adder (
    output logic [31:0] sum,
    output logic        cout,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// rtl/shift_add_mult_ctrl.sv - sequential 32x32 shift-add multiplier; SIGNED_MULT_EN enables MULT
module shift_add_mult_ctrl
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] multiplicand,
    input  logic [DATA_W-1:0] multiplier,
    input  logic              is_signed,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam logic [4:0] LAST_ITER = 5'(ITER_COUNT - 1);

    mult_state_t       state, state_next;
    logic [DATA_W-1:0] mcand;
    logic [4:0]        count;
    logic [DATA_W-1:0] add_a, add_b, add_sum;
    logic              add_cin, add_cout;
    logic [DATA_W-1:0] cap_a, cap_b;

`ifdef SIGNED_MULT_EN
    logic sign, mode_signed, carry_q;

    // magnitudes are formed at capture so CALC is always an unsigned loop
    assign cap_a = (is_signed && multiplicand[31]) ? -multiplicand : multiplicand;
    assign cap_b = (is_signed && multiplier[31])   ? -multiplier   : multiplier;
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
    assign cap_a = multiplicand;
    assign cap_b = multiplier;
`endif

    _32bit_adder u_adder (
        .sum  (add_sum),
        .cout (add_cout),
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin)
    );

    always_comb begin
        state_next = state;
        add_a      = hi;
        add_b      = '0;
        add_cin    = 1'b0;
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: begin
                add_b = lo[0] ? mcand : '0;
                if (count == LAST_ITER) begin
`ifdef SIGNED_MULT_EN
                    state_next = mode_signed ? NEG_LO : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef SIGNED_MULT_EN
            NEG_LO: begin
                add_a      = ~lo;
                add_cin    = sign;
                state_next = NEG_HI;
            end
            NEG_HI: begin
                add_a      = ~hi;
                add_cin    = carry_q;
                state_next = DONE;
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SIGNED_MULT_EN
            sign        <= 1'b0;
            mode_signed <= 1'b0;
            carry_q     <= 1'b0;
`endif
        end else begin
            state <= state_next;
            busy  <= (state_next == CALC) || (state_next == NEG_LO) || (state_next == NEG_HI);
            done  <= (state_next == DONE);
            case (state)
                IDLE: if (start) begin
                    hi    <= '0;
                    lo    <= cap_b;
                    mcand <= cap_a;
                    count <= '0;
`ifdef SIGNED_MULT_EN
                    sign        <= is_signed & (multiplicand[31] ^ multiplier[31]);
                    mode_signed <= is_signed;
`endif
                end
                CALC: begin
                    {hi, lo} <= {add_cout, add_sum, lo[DATA_W-1:1]};
                    count    <= count + 5'd1;
                end
`ifdef SIGNED_MULT_EN
                NEG_LO: begin
                    if (sign) lo <= add_sum;
                    carry_q <= add_cout;
                end
                NEG_HI: if (sign) hi <= add_sum;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb/tb_shift_add_mult_ctrl.sv - directed self-checking bench for shift_add_mult_ctrl
module tb_shift_add_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        is_signed = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    shift_add_mult_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .is_signed    (is_signed),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // accept edge is cycle 1; lat is the cycle count at which done is seen
    task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input int poke_at,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_lat);
        int lat;
        int d0;
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        is_signed    = s;
        start        = 1'b1;
        d0           = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        check_val({tag, "_busy"}, {63'b0, busy}, 64'd1);
        while (!done && lat < 100) begin
            if (lat == poke_at) begin
                start        = 1'b1;
                multiplicand = 32'd2;
                multiplier   = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_busy_at_done"}, {63'b0, busy}, 64'd0);
        check_val({tag, "_hi"}, {32'b0, hi}, {32'b0, exp_hi});
        check_val({tag, "_lo"}, {32'b0, lo}, {32'b0, exp_lo});
        repeat (4) @(posedge clk);
        #1;
        check_val({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check_val({tag, "_hold"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    localparam int LAT_U = 33;
`ifdef SIGNED_MULT_EN
    localparam int LAT_S = 35;
`else
    localparam int LAT_S = 33;
`endif

    initial begin
        int d0;
        #12;
        check_val("rst_hi",   {32'b0, hi}, 64'd0);
        check_val("rst_lo",   {32'b0, lo}, 64'd0);
        check_val("rst_busy", {63'b0, busy}, 64'd0);
        check_val("rst_done", {63'b0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_mult("u_max",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 32'hFFFFFFFE, 32'h00000001, LAT_U);
        do_mult("u_zero",  32'h0003FFFF, 32'h00000000, 1'b0, 0, 32'h0, 32'h0, LAT_U);
        do_mult("u_one",   32'h0003FFFF, 32'h00000001, 1'b0, 0, 32'h0, 32'h0003FFFF, LAT_U);
        do_mult("u_carry", 32'h80000000, 32'h00000002, 1'b0, 0, 32'h1, 32'h0, LAT_U);
`ifdef SIGNED_MULT_EN
        do_mult("s_m1x1",   32'hFFFFFFFF, 32'h00000001, 1'b1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_S);
        do_mult("s_min2",   32'h80000000, 32'h80000000, 1'b1, 0, 32'h40000000, 32'h0, LAT_S);
        do_mult("s_minx1",  32'h80000000, 32'h00000001, 1'b1, 0, 32'hFFFFFFFF, 32'h80000000, LAT_S);
        do_mult("s_m3x5",   32'hFFFFFFFD, 32'h00000005, 1'b1, 0, 32'hFFFFFFFF, 32'hFFFFFFF1, LAT_S);
        do_mult("s_m3xm5",  32'hFFFFFFFD, 32'hFFFFFFFB, 1'b1, 0, 32'h0, 32'd15, LAT_S);
`else
        do_mult("s_m1x1",   32'hFFFFFFFF, 32'h00000001, 1'b1, 0, 32'h0, 32'hFFFFFFFF, LAT_S);
        do_mult("s_min2",   32'h80000000, 32'h80000000, 1'b1, 0, 32'h40000000, 32'h0, LAT_S);
        do_mult("s_minx1",  32'h80000000, 32'h00000001, 1'b1, 0, 32'h0, 32'h80000000, LAT_S);
        do_mult("s_m3x5",   32'hFFFFFFFD, 32'h00000005, 1'b1, 0, 32'h4, 32'hFFFFFFF1, LAT_S);
`endif
        do_mult("busy_start", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5, 32'hFFFFFFFE, 32'h00000001, LAT_U);

        // reset in the middle of CALC
        @(negedge clk);
        multiplicand = 32'd7;
        multiplier   = 32'd9;
        is_signed    = 1'b0;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        d0    = done_cnt;
        rst_n = 1'b0;
        #1;
        check_val("abort_hi",   {32'b0, hi}, 64'd0);
        check_val("abort_lo",   {32'b0, lo}, 64'd0);
        check_val("abort_busy", {63'b0, busy}, 64'd0);
        check_val("abort_done", {63'b0, done}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_val("abort_no_done", 64'(done_cnt - d0), 64'd0);
        do_mult("post_rst", 32'd3, 32'd5, 1'b0, 0, 32'h0, 32'd15, LAT_U);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_add_mult_ctrl.md
SHIFT_ADD_MULT_CTRL -- requirements
Module: shift_add_mult_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 start  input  1  request new multiply; sampled only in IDLE.
REQ-004 multiplicand  input  32  operand A; captured on the accepted start edge.
REQ-005 multiplier  input  32  operand B; captured on the accepted start edge.
REQ-006 is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; captured with the operands.
REQ-007 busy  output  1  high from the accept edge until the DONE state is entered.
REQ-008 done  output  1  one-cycle pulse; hi/lo valid.
REQ-009 hi  output  32  upper product word; holds its value until the next accept.
REQ-010 lo  output  32  lower product word; holds its value until the next accept.

Function
REQ-011 States SHALL be IDLE, CALC, NEG_LO, NEG_HI and DONE.
REQ-012 IDLE with start=1 SHALL capture operands: {hi,lo} <= {32'h0, B}, mcand <= A, count <= 0, next state CALC.
REQ-013 Each CALC cycle SHALL add mcand to hi through the single shared 32-bit adder (cin=0) if lo[0]=1, else add 0, then {hi,lo} <= {cout, sum, lo[31:1]}.
REQ-014 CALC SHALL last exactly 32 cycles (count 0..31), then go to NEG_LO if the captured is_signed=1, else to DONE.
REQ-015 NEG_LO SHALL drive adder a=~lo, b=0, cin=sign; write lo, latch cout; NEG_HI SHALL drive a=~hi, b=0, cin=latched cout when sign=1, else leave hi/lo unchanged; NEG_HI -> DONE.
REQ-016 sign = A[31]^B[31] at capture; in signed mode operands SHALL be replaced by magnitudes (combinational two's-complement negate) at capture.
REQ-017 Latency from the accept edge to done high: unsigned 33 cycles, signed 35 cycles, fixed and data independent.
REQ-018 DONE SHALL assert done for one cycle with busy=0, then return to IDLE; a start in DONE SHALL be ignored.
REQ-019 start while busy SHALL be ignored; operands SHALL NOT be re-sampled.
REQ-020 The magnitude of -2^31 (0x80000000) SHALL be treated as unsigned 2^31; no overflow flag.
REQ-021 The adder SHALL be the only arithmetic path for CALC/NEG_* (one instance, time-shared).

Reset
REQ-022 rst_n low SHALL, asynchronously: state=IDLE, hi=0, lo=0, mcand=0, count=0, sign=0, busy=0, done=0.
REQ-023 Reset mid-operation SHALL abort it with no done pulse; the first start after release SHALL behave per REQ-012.

Configuration
REQ-024 Macro SIGNED_MULT_EN defined: is_signed honoured per REQ-014..016.
REQ-025 SIGNED_MULT_EN undefined: is_signed ignored, NEG_LO/NEG_HI and sign logic absent, all operations unsigned with 33-cycle latency.

Structure
REQ-026 Shared package mult_pkg SHALL hold the state encodings, ITER_COUNT=32 and DATA_W=32.
REQ-027 Exactly one sub-module: the existing _32bit_adder (ports: sum, cout, a, b, cin), with the operand muxing in this block.

Verification
REQ-028 Unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done 33 cycles after accept.
REQ-029 Unsigned 0x0003FFFF*0x00000000 -> hi=0, lo=0; 0x0003FFFF*0x00000001 -> hi=0, lo=0x0003FFFF.
REQ-030 Signed (macro on) 0xFFFFFFFF*0x00000001 -> hi=lo=0xFFFFFFFF at 35 cycles; macro off -> hi=0, lo=0xFFFFFFFF at 33 cycles.
REQ-031 Signed 0x80000000*0x80000000 -> hi=0x40000000, lo=0; 0x80000000*0x00000001 -> hi=0xFFFFFFFF, lo=0x80000000.
REQ-032 start pulsed at cycle 5 of a busy operation with new operands -> ignored; the original result is unchanged and there is a single done pulse.
REQ-033 rst_n low at cycle 10 of CALC -> all outputs 0 immediately with no done; a following 3*5 request -> lo=15, hi=0.
